hist_table_sched: RTL and testbench

//  Time-multiplexes the single-port event history table among all phold cores.

---
 rtl/phold_pkg.sv | 20 ++
 rtl/rr_pick.sv | 37 +++
 rtl/hist_table_sched.sv | 182 ++++++++++++++++++
 tb/tb_hist_table_sched.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phold_pkg.sv
// Shared phold definitions: core/table geometry defaults, history entry type and
// the encoding of the history-table scheduler FSM.
package phold_pkg;

  localparam int unsigned NUM_CORE      = 16;
  localparam int unsigned NB_COREID     = 4;
  localparam int unsigned NB_LPID       = 5;
  localparam int unsigned NB_HIST_DEPTH = 4;
  localparam int unsigned NB_HIST_ADDR  = NB_LPID + NB_HIST_DEPTH;
  localparam int unsigned HIST_WID      = 32;
  localparam int unsigned MAX_BURST     = 8;
  localparam int unsigned RD_LAT        = 1;

  typedef logic [HIST_WID-1:0] hist_entry_t;

  // Scheduler FSM encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker. Selects the first requester strictly after
// 'last', wrapping around to index 0.
//   req      in   per-core request vector
//   last     in   index of the previous owner
//   pick_oh  out  one-hot selected core (zero when nobody requests)
//   pick_idx out  index of the selected core
//   pick_any out  at least one request present
module rr_pick #(
  parameter int unsigned NUM_CORE  = phold_pkg::NUM_CORE,
  parameter int unsigned NB_COREID = phold_pkg::NB_COREID
) (
  input  logic [NUM_CORE-1:0]  req,
  input  logic [NB_COREID-1:0] last,
  output logic [NUM_CORE-1:0]  pick_oh,
  output logic [NB_COREID-1:0] pick_idx,
  output logic                 pick_any
);

  int unsigned cand;

  always_comb begin
    pick_any = 1'b0;
    pick_idx = '0;
    pick_oh  = '0;
    cand     = 0;
    // Scan last+1 .. last+NUM_CORE so 'last' itself is considered last.
    for (int unsigned k = 1; k <= NUM_CORE; k++) begin
      cand = (32'(last) + k) % NUM_CORE;
      if (!pick_any && req[NB_COREID'(cand)]) begin
        pick_any = 1'b1;
        pick_idx = NB_COREID'(cand);
      end
    end
    if (pick_any) pick_oh[pick_idx] = 1'b1;
  end

endmodule

// File: rtl/hist_table_sched.sv
// History table scheduler: time-multiplexes the single-port history table among
// the phold cores with burst-aware round-robin ownership. The owner issues
// back-to-back accesses; reads return to the issuing core via a latency pipe.
// Optional statistics are enabled by defining HIST_SCHED_STATS_EN.
//   clk, rst_n         clock, asynchronous active-low reset
//   req/wr_en          per-core request level and write(1)/read(0) qualifier
//   addr/wdata         per-core packed address / write data (core i at slice i)
//   gnt                one-hot owner; an access issues on cycles with req&gnt
//   rd_vld/rd_data     one-hot read return strobe and broadcast read data
//   tbl_we/addr/din    table command, combinational from the owner's slice
//   tbl_dout           table read data, RD_LAT cycles after issue
//   busy               a core owns the table
//   stat_access/wait/preempt (HIST_SCHED_STATS_EN only) saturating counters
module hist_table_sched #(
  parameter int unsigned NUM_CORE     = phold_pkg::NUM_CORE,
  parameter int unsigned NB_COREID    = phold_pkg::NB_COREID,
  parameter int unsigned NB_HIST_ADDR = phold_pkg::NB_HIST_ADDR,
  parameter int unsigned HIST_WID     = phold_pkg::HIST_WID,
  parameter int unsigned MAX_BURST    = phold_pkg::MAX_BURST,
  parameter int unsigned RD_LAT       = phold_pkg::RD_LAT
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_CORE-1:0]              req,
  input  logic [NUM_CORE-1:0]              wr_en,
  input  logic [NUM_CORE*NB_HIST_ADDR-1:0] addr,
  input  logic [NUM_CORE*HIST_WID-1:0]     wdata,
  output logic [NUM_CORE-1:0]              gnt,
  output logic [NUM_CORE-1:0]              rd_vld,
  output logic [HIST_WID-1:0]              rd_data,
  output logic                             tbl_we,
  output logic [NB_HIST_ADDR-1:0]          tbl_addr,
  output logic [HIST_WID-1:0]              tbl_din,
  input  logic [HIST_WID-1:0]              tbl_dout,
  output logic                             busy
`ifdef HIST_SCHED_STATS_EN
  ,
  output logic [31:0]                      stat_access,
  output logic [31:0]                      stat_wait,
  output logic [15:0]                      stat_preempt
`endif
);

  import phold_pkg::*;

  localparam int unsigned NB_BURST = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic [0:0]           state_q, state_d;
  logic [NUM_CORE-1:0]  gnt_q, gnt_d;
  logic [NB_COREID-1:0] last_q, last_d;   // doubles as the current owner in ST_OWN
  logic [NB_BURST-1:0]  burst_q, burst_d;

  logic [NUM_CORE-1:0]  pick_oh;
  logic [NB_COREID-1:0] pick_idx;
  logic                 pick_any;

  logic req_own, wr_own, issue, others, burst_last, preempt;

  rr_pick #(
    .NUM_CORE  (NUM_CORE),
    .NB_COREID (NB_COREID)
  ) u_rr_pick (
    .req      (req),
    .last     (last_q),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .pick_any (pick_any)
  );

  // Owner slice mux; constant slice indices keep the select simple.
  always_comb begin
    tbl_addr = '0;
    tbl_din  = '0;
    wr_own   = 1'b0;
    for (int i = 0; i < int'(NUM_CORE); i++) begin
      if (last_q == NB_COREID'(i)) begin
        tbl_addr = addr[i*NB_HIST_ADDR +: NB_HIST_ADDR];
        tbl_din  = wdata[i*HIST_WID +: HIST_WID];
        wr_own   = wr_en[i];
      end
    end
  end

  assign req_own    = req[last_q];
  assign issue      = (state_q == ST_OWN) && req_own;
  assign others     = |(req & ~gnt_q);
  assign burst_last = (burst_q == NB_BURST'(MAX_BURST - 1));
  assign preempt    = issue && burst_last && others;
  assign tbl_we     = issue && wr_own;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    burst_d = burst_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_OWN;
          gnt_d   = pick_oh;
          last_d  = pick_idx;
          burst_d = '0;
        end
      end
      ST_OWN: begin
        if (!req_own || preempt) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end else if (!burst_last) begin
          // Saturates so a lone owner keeps the table indefinitely.
          burst_d = burst_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= NB_COREID'(NUM_CORE - 1);
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = (state_q == ST_OWN);

  // Read return pipe: {valid, core id} per issued read, independent of ownership
  // so reads issued right before a handover still return to their issuer.
  logic [RD_LAT-1:0]                pipe_vld_q;
  logic [RD_LAT-1:0][NB_COREID-1:0] pipe_id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_q <= '0;
      pipe_id_q  <= '0;
    end else begin
      pipe_vld_q[0] <= issue && !wr_own;
      pipe_id_q[0]  <= last_q;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_id_q[i]  <= pipe_id_q[i-1];
      end
    end
  end

  always_comb begin
    rd_vld = '0;
    if (pipe_vld_q[RD_LAT-1]) rd_vld[pipe_id_q[RD_LAT-1]] = 1'b1;
  end

  assign rd_data = pipe_vld_q[RD_LAT-1] ? tbl_dout : '0;

`ifdef HIST_SCHED_STATS_EN
  logic [31:0] stat_access_q, stat_wait_q;
  logic [15:0] stat_preempt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_access_q  <= '0;
      stat_wait_q    <= '0;
      stat_preempt_q <= '0;
    end else begin
      if (issue && (stat_access_q != '1))    stat_access_q  <= stat_access_q + 1'b1;
      if (others && (stat_wait_q != '1))     stat_wait_q    <= stat_wait_q + 1'b1;
      if (preempt && (stat_preempt_q != '1)) stat_preempt_q <= stat_preempt_q + 1'b1;
    end
  end

  assign stat_access  = stat_access_q;
  assign stat_wait    = stat_wait_q;
  assign stat_preempt = stat_preempt_q;
`endif

endmodule

// File: tb/tb_hist_table_sched.sv
// Directed bench for hist_table_sched (MAX_BURST=4, RD_LAT=2) with a behavioural
// single-port history table. Unwritten table words read as 0xA0000000 | addr.
module tb_hist_table_sched;

  localparam int NC = 16;
  localparam int NA = 9;
  localparam int NW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NC-1:0]   req, wr_en, gnt, rd_vld;
  logic [NC*NA-1:0] addr;
  logic [NC*NW-1:0] wdata;
  logic [NW-1:0]   rd_data, tbl_din, tbl_dout;
  logic [NA-1:0]   tbl_addr;
  logic            tbl_we, busy;
`ifdef HIST_SCHED_STATS_EN
  logic [31:0]     stat_access, stat_wait;
  logic [15:0]     stat_preempt;
`endif

  always #5 clk = ~clk;

  hist_table_sched #(
    .NUM_CORE     (NC),
    .NB_COREID    (4),
    .NB_HIST_ADDR (NA),
    .HIST_WID     (NW),
    .MAX_BURST    (4),
    .RD_LAT       (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .wr_en    (wr_en),
    .addr     (addr),
    .wdata    (wdata),
    .gnt      (gnt),
    .rd_vld   (rd_vld),
    .rd_data  (rd_data),
    .tbl_we   (tbl_we),
    .tbl_addr (tbl_addr),
    .tbl_din  (tbl_din),
    .tbl_dout (tbl_dout),
    .busy     (busy)
`ifdef HIST_SCHED_STATS_EN
    ,
    .stat_access  (stat_access),
    .stat_wait    (stat_wait),
    .stat_preempt (stat_preempt)
`endif
  );

  // Table model: read-first single port, two-cycle read latency.
  logic [NW-1:0] mem [512];
  bit            written [512];
  logic [NW-1:0] rd_s1, rd_s2;
  always @(posedge clk) begin
    if (tbl_we) begin
      mem[tbl_addr]     <= tbl_din;
      written[tbl_addr] <= 1'b1;
    end
    rd_s1 <= written[tbl_addr] ? mem[tbl_addr] : (32'hA000_0000 | {23'd0, tbl_addr});
    rd_s2 <= rd_s1;
  end
  assign tbl_dout = rd_s2;

  int n_checks = 0;
  int n_pass   = 0;

  // Scheduler scenario configuration and observations
  int  quota [NC];
  int  start_at [NC];
  int  base [NC];
  int  cnt [NC];
  bit  wr_mode [NC];
  bit  done_c [NC];
  int  order_q [$];
  int  burst_q [$];
  int  rd_core_q [$];
  logic [NW-1:0] rd_dat_q [$];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int c, input bit wr, input logic [NA-1:0] a,
                          input logic [NW-1:0] d);
    wr_en[c]          = wr;
    addr[c*NA +: NA]  = a;
    wdata[c*NW +: NW] = d;
  endtask

  task automatic clear_cfg();
    for (int c = 0; c < NC; c++) begin
      quota[c] = 0; start_at[c] = 0; base[c] = 0; cnt[c] = 0;
      wr_mode[c] = 1'b0; done_c[c] = 1'b0;
    end
    order_q.delete(); burst_q.delete(); rd_core_q.delete(); rd_dat_q.delete();
  endtask

  // Drives each configured core: req high from start_at until quota accesses
  // have issued; records owner order, burst lengths and read returns.
  task automatic run_sched(input int max_cyc);
    logic [NC-1:0] prev;
    int cur_burst, gap, idx;
    bit seen, all_done;
    prev = gnt; cur_burst = 0; gap = 0; seen = 1'b0;
    for (int it = 0; it < max_cyc; it++) begin
      cyc();
      for (int c = 0; c < NC; c++) begin
        req[c] = (quota[c] > 0) && (it >= start_at[c]) && !done_c[c];
        set_slot(c, wr_mode[c], NA'(base[c] + cnt[c]), 32'hC0DE_0000 + c * 256 + cnt[c]);
      end
      #1;
      if (gnt != 0 && gnt != prev) begin
        idx = 0;
        for (int c = 0; c < NC; c++) if (gnt[c]) idx = c;
        order_q.push_back(idx);
        if (seen) begin
          n_checks++;
          if (gap !== 1) $display("FAIL handover_gap: got %0d dead cycles, expected 1", gap);
          else n_pass++;
        end
        seen = 1'b1; gap = 0;
      end
      if (gnt == 0 && prev != 0) begin
        burst_q.push_back(cur_burst);
        cur_burst = 0;
      end
      if (gnt == 0 && seen) gap++;
      for (int c = 0; c < NC; c++) begin
        if (gnt[c] && req[c]) begin
          n_checks++;
          if (tbl_addr !== NA'(base[c] + cnt[c]) || tbl_we !== wr_mode[c])
            $display("FAIL issue_bus core %0d: got addr %h we %b, expected addr %h we %b",
                     c, tbl_addr, tbl_we, NA'(base[c] + cnt[c]), wr_mode[c]);
          else n_pass++;
          cnt[c]++; cur_burst++;
          if (cnt[c] == quota[c]) done_c[c] = 1'b1;
        end
      end
      if (rd_vld != 0) begin
        idx = 0;
        for (int c = NC - 1; c >= 0; c--) if (rd_vld[c]) idx = c;
        rd_core_q.push_back(idx);
        rd_dat_q.push_back(rd_data);
      end
      prev = gnt;
    end
    all_done = 1'b1;
    for (int c = 0; c < NC; c++) if (quota[c] > 0 && !done_c[c]) all_done = 1'b0;
    n_checks++;
    if (!all_done) $display("FAIL sched_timeout: got unfinished cores, expected all served");
    else n_pass++;
    req = '0;
  endtask

  task automatic check_order3(input string name, input int e0, input int e1, input int e2);
    n_checks++;
    if (order_q.size() != 3 || order_q[0] != e0 || order_q[1] != e1 || order_q[2] != e2)
      $display("FAIL %s: got %0d grants [%0d %0d %0d], expected [%0d %0d %0d]", name,
               order_q.size(), order_q[0], order_q[1], order_q[2], e0, e1, e2);
    else n_pass++;
  endtask

  task automatic test_reset();
    cyc();
    n_checks += 5;
    if (gnt !== '0)     $display("FAIL reset_gnt: got %h expected 0", gnt);     else n_pass++;
    if (rd_vld !== '0)  $display("FAIL reset_rd_vld: got %h expected 0", rd_vld); else n_pass++;
    if (busy !== 1'b0)  $display("FAIL reset_busy: got %b expected 0", busy);   else n_pass++;
    if (tbl_we !== 1'b0) $display("FAIL reset_tbl_we: got %b expected 0", tbl_we); else n_pass++;
    if (rd_data !== '0) $display("FAIL reset_rd_data: got %h expected 0", rd_data); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    cyc();
    req[3] = 1'b1;
    set_slot(3, 1'b1, 9'h041, 32'hDEAD_BEEF);
    #1;
    n_checks++;
    if (gnt !== '0) $display("FAIL wr_gnt_early: got %h expected 0", gnt); else n_pass++;
    cyc();
    n_checks += 4;
    if (gnt !== 16'h0008) $display("FAIL wr_gnt: got %h expected 0008", gnt); else n_pass++;
    if (busy !== 1'b1) $display("FAIL wr_busy: got %b expected 1", busy); else n_pass++;
    if (tbl_we !== 1'b1 || tbl_addr !== 9'h041)
      $display("FAIL wr_cmd: got we %b addr %h expected we 1 addr 041", tbl_we, tbl_addr);
    else n_pass++;
    if (tbl_din !== 32'hDEAD_BEEF) $display("FAIL wr_din: got %h expected deadbeef", tbl_din);
    else n_pass++;
    cyc();
    wr_en[3] = 1'b0;
    #1;
    n_checks++;
    if (tbl_we !== 1'b0) $display("FAIL rd_we: got %b expected 0", tbl_we); else n_pass++;
    cyc();
    req[3] = 1'b0;
    #1;
    n_checks++;
    if (rd_vld !== '0) $display("FAIL rd_vld_early: got %h expected 0", rd_vld); else n_pass++;
    cyc();
    n_checks += 3;
    if (rd_vld !== 16'h0008) $display("FAIL rd_vld: got %h expected 0008", rd_vld); else n_pass++;
    if (rd_data !== 32'hDEAD_BEEF) $display("FAIL rd_data: got %h expected deadbeef", rd_data);
    else n_pass++;
    if (gnt !== '0) $display("FAIL rd_release: got %h expected 0", gnt); else n_pass++;
    cyc();
    n_checks++;
    if (rd_vld !== '0) $display("FAIL rd_vld_once: got %h expected 0", rd_vld); else n_pass++;
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      clear_cfg();
      quota[2] = 1; base[2] = 9'h020;
      quota[5] = 1; base[5] = 9'h050;
      quota[9] = 1; base[9] = 9'h090;
      run_sched(20);
      check_order3(pass == 0 ? "rr_order_first" : "rr_order_repeat", 2, 5, 9);
      n_checks++;
      if (rd_core_q.size() != 3 || rd_core_q[0] != 2 || rd_core_q[1] != 5 || rd_core_q[2] != 9 ||
          rd_dat_q[0] !== 32'hA000_0020 || rd_dat_q[2] !== 32'hA000_0090)
        $display("FAIL rr_returns: got %0d returns first core %0d data %h, expected 3 cores 2,5,9",
                 rd_core_q.size(), rd_core_q[0], rd_dat_q[0]);
      else n_pass++;
    end
  endtask

  task automatic test_burst_limit();
`ifdef HIST_SCHED_STATS_EN
    logic [31:0] acc0;
    logic [15:0] pre0;
    acc0 = stat_access;
    pre0 = stat_preempt;
`endif
    clear_cfg();
    quota[0] = 10; wr_mode[0] = 1'b1; base[0] = 9'h1A0;
    quota[1] = 2;  wr_mode[1] = 1'b1; base[1] = 9'h1C0; start_at[1] = 2;
    run_sched(30);
    check_order3("burst_order", 0, 1, 0);
    n_checks++;
    if (burst_q.size() != 3 || burst_q[0] != 4 || burst_q[1] != 2 || burst_q[2] != 6)
      $display("FAIL burst_lengths: got [%0d %0d %0d] expected [4 2 6]",
               burst_q[0], burst_q[1], burst_q[2]);
    else n_pass++;
`ifdef HIST_SCHED_STATS_EN
    n_checks += 2;
    if (stat_preempt - pre0 !== 16'd1)
      $display("FAIL stat_preempt: got %0d expected 1", stat_preempt - pre0);
    else n_pass++;
    if (stat_access - acc0 !== 32'd12)
      $display("FAIL stat_access: got %0d expected 12", stat_access - acc0);
    else n_pass++;
`endif
  endtask

  task automatic test_preempt_reads();
    clear_cfg();
    quota[7] = 6; base[7] = 9'h100;
    quota[8] = 1; base[8] = 9'h1F0; wr_mode[8] = 1'b1; start_at[8] = 5;
    run_sched(30);
    check_order3("preempt_order", 7, 8, 7);
    n_checks++;
    if (rd_core_q.size() != 6)
      $display("FAIL preempt_rd_count: got %0d expected 6", rd_core_q.size());
    else n_pass++;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (rd_core_q[k] != 7 || rd_dat_q[k] !== 32'hA000_0100 + k)
        $display("FAIL preempt_rd_%0d: got core %0d data %h, expected core 7 data %h",
                 k, rd_core_q[k], rd_dat_q[k], 32'hA000_0100 + k);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_burst();
    bit stale;
    cyc();
    req[4] = 1'b1;
    set_slot(4, 1'b0, 9'h010, 32'h0);
    cyc();
    cyc();
    cyc();
    n_checks++;
    if (rd_vld !== 16'h0010) $display("FAIL mid_rd_vld: got %h expected 0010", rd_vld);
    else n_pass++;
    rst_n = 1'b0;
    req[4] = 1'b0;
    #1;
    n_checks += 3;
    if (gnt !== '0)    $display("FAIL mid_rst_gnt: got %h expected 0", gnt);       else n_pass++;
    if (rd_vld !== '0) $display("FAIL mid_rst_rd_vld: got %h expected 0", rd_vld); else n_pass++;
    if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b expected 0", busy);     else n_pass++;
    cyc();
    cyc();
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (rd_vld !== '0) stale = 1'b1;
    end
    n_checks++;
    if (stale) $display("FAIL mid_stale_rd: got stale rd_vld, expected none"); else n_pass++;
    req[3] = 1'b1;
    req[6] = 1'b1;
    set_slot(3, 1'b0, 9'h030, 32'h0);
    set_slot(6, 1'b0, 9'h060, 32'h0);
    cyc();
    n_checks++;
    if (gnt !== 16'h0008) $display("FAIL mid_rr_restart: got %h expected 0008", gnt);
    else n_pass++;
    req = '0;
    repeat (4) cyc();
  endtask

  initial begin
    req = '0; wr_en = '0; addr = '0; wdata = '0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_burst_limit();
    test_preempt_reads();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
